// File: rtl/alu_pkg.sv
// ALU opcode definitions shared by the driver, the DUT and the monitor.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_SLT = 4'd8
    } opcode_e;

endpackage

// File: rtl/alu_tb_pkg.sv
// Monitor record types, flag bit positions and default id width.
package alu_tb_pkg;
    import alu_pkg::*;

    localparam int MON_ID_W  = 16;
    localparam int MON_WIDTH = 32;

    // Bit positions inside dut_flags = {negative, overflow, carry, zero}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    // Transaction as captured from the driver, before the result is known.
    typedef struct packed {
        logic [MON_ID_W-1:0]  id;
        logic [MON_WIDTH-1:0] a;
        logic [MON_WIDTH-1:0] b;
        opcode_e              opcode;
        logic                 signed_op;
    } mon_txn_t;

    // Completed record handed to the scoreboard.
    typedef struct packed {
        logic [MON_ID_W-1:0]  id;
        logic [MON_WIDTH-1:0] a;
        logic [MON_WIDTH-1:0] b;
        opcode_e              opcode;
        logic                 signed_op;
        logic [MON_WIDTH-1:0] result;
        logic [3:0]           flags;
    } mon_rec_t;

endpackage

// File: rtl/alu_mon_fifo.sv
// First-word fall-through record buffer. A push into a full buffer is
// accepted only when a pop happens on the same edge; otherwise it is
// reported on push_drop and discarded. When empty, out_data keeps showing
// the last record that was presented.
module alu_mon_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_valid,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop_ready,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   push_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          empty, full, pop_en, push_en;

    // Occupancy, handshake qualification, head selection and next state.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        pop_en    = !empty && pop_ready;
        push_en   = push_valid && (!full || pop_en);
        push_drop = push_valid && full && !pop_en;

        out_valid = !empty;
        out_data  = empty ? hold_q : mem_q[rd_ptr_q];
        hold_d    = out_data;
        count     = count_q;

        wr_ptr_d  = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_en  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};

        mem_d = mem_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    // Pointer, occupancy and held-head registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage array; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_monitor.sv
// Receive side of the ALU stimulus interface. Captures each driver
// transaction, delays it by DUT_LATENCY edges so it lines up with the DUT
// result, pairs the two into a record and buffers it for the scoreboard.
//
// Scoreboard port: a record transfers on a posedge where out_valid and
// out_ready are both high. Once out_valid is high it stays high, and
// out_rec stays unchanged, until that transfer happens. out_ready is
// ignored while out_valid is low.
module alu_monitor
    import alu_pkg::*;
    import alu_tb_pkg::*;
#(
    parameter int WIDTH       = MON_WIDTH,
    parameter int DUT_LATENCY = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int ID_W        = MON_ID_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mon_valid,
    input  logic [WIDTH-1:0]            operand_a,
    input  logic [WIDTH-1:0]            operand_b,
    input  opcode_e                     opcode,
    input  logic                        signed_op,
    input  logic [WIDTH-1:0]            dut_result,
    input  logic [3:0]                  dut_flags,
    output logic                        out_valid,
    input  logic                        out_ready,
    output mon_rec_t                    out_rec,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 dropped_count,
    output logic                        overflow_err
);

    logic [ID_W-1:0] id_q, id_d;
    logic [15:0]     dropped_q, dropped_d;
    logic            overflow_q, overflow_d;
    mon_txn_t        cap_txn;
    mon_txn_t        tail_txn;
    logic            tail_vld;
    mon_rec_t        push_rec;
    logic            push_drop;

    // Build the captured transaction and advance the id on every capture.
    always_comb begin
        cap_txn           = '0;
        cap_txn.id        = id_q;
        cap_txn.a         = operand_a;
        cap_txn.b         = operand_b;
        cap_txn.opcode    = opcode;
        cap_txn.signed_op = signed_op;
        id_d              = mon_valid ? id_q + ID_W'(1) : id_q;
    end

    if (DUT_LATENCY == 0) begin : g_direct
        // Zero latency: the capture edge is also the pairing edge.
        always_comb begin
            tail_vld = mon_valid;
            tail_txn = cap_txn;
        end
    end else begin : g_delay
        logic [DUT_LATENCY-1:0] stage_vld_q, stage_vld_d;
        mon_txn_t               stage_q [DUT_LATENCY];
        mon_txn_t               stage_d [DUT_LATENCY];

        // Shift the transaction one stage per edge; the last stage pairs.
        always_comb begin
            stage_vld_d[0] = mon_valid;
            stage_d[0]     = cap_txn;
            for (int i = 1; i < DUT_LATENCY; i++) begin
                stage_vld_d[i] = stage_vld_q[i-1];
                stage_d[i]     = stage_q[i-1];
            end
            tail_vld = stage_vld_q[DUT_LATENCY-1];
            tail_txn = stage_q[DUT_LATENCY-1];
        end

        // Delay-line registers; reset drops anything still in flight.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stage_vld_q <= '0;
                for (int i = 0; i < DUT_LATENCY; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_vld_q <= stage_vld_d;
                for (int i = 0; i < DUT_LATENCY; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end
    end

    // Pair the aligned transaction with the result and flags seen this edge.
    always_comb begin
        push_rec           = '0;
        push_rec.id        = tail_txn.id;
        push_rec.a         = tail_txn.a;
        push_rec.b         = tail_txn.b;
        push_rec.opcode    = tail_txn.opcode;
        push_rec.signed_op = tail_txn.signed_op;
        push_rec.result    = dut_result;
        push_rec.flags     = dut_flags;
    end

    alu_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    ($bits(mon_rec_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (tail_vld),
        .push_data  (push_rec),
        .pop_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_rec),
        .count      (fifo_count),
        .push_drop  (push_drop)
    );

    // Saturating drop counter and sticky overflow flag.
    always_comb begin
        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        if (push_drop) begin
            if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end
            overflow_d = 1'b1;
        end
    end

    // Id counter and drop bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q       <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            id_q       <= id_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    assign dropped_count = dropped_q;
    assign overflow_err  = overflow_q;

endmodule
